// File: rtl/neg_abs_unit.sv
// neg_abs_unit: digit-serial two's-complement pass/negate/abs/nabs with overflow and zero flags
module neg_abs_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int N = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_r, res, res_n;
    logic [CW-1:0] cnt;
    logic neg, carry, ovf, neg_in, last;
    logic [DIGIT-1:0] digit;
    logic [DIGIT:0] sum;
    always_comb begin
        neg_in = (in_mode == 2'd1) | (in_mode == 2'd2 & in_data[WIDTH-1]) | (in_mode == 2'd3 & ~in_data[WIDTH-1]);
        digit = a_r[cnt*DIGIT +: DIGIT];
        sum = {1'b0, neg ? ~digit : digit} + {{DIGIT{1'b0}}, carry};
        res_n = res;
        res_n[cnt*DIGIT +: DIGIT] = sum[DIGIT-1:0];
        last = cnt == CW'(N - 1);
        in_ready = state == IDLE && !reset;
        out_valid = state == DONE;
        state_n = state == IDLE ? (in_valid && in_ready ? BUSY : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) :
                  state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_r <= '0;
            res <= '0;
            cnt <= '0;
            neg <= 1'b0;
            carry <= 1'b0;
            ovf <= 1'b0;
            out_data <= '0;
            out_ovf <= 1'b0;
            out_zero <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                a_r <= in_data;
                cnt <= '0;
                neg <= neg_in;
                carry <= neg_in;
                ovf <= neg_in && in_data == MIN_VAL;
            end
            if (state == BUSY) begin
                res <= res_n;
                carry <= sum[DIGIT];
                cnt <= cnt + 1'b1;
                // outputs load only on DONE entry so they stay put through the next BUSY
                if (last) begin
                    out_data <= res_n;
                    out_ovf <= ovf;
                    out_zero <= res_n == '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_neg_abs_unit.sv
// tb_neg_abs_unit: three configurations (32/8, 32/1, 16/16) checked against an integer-arithmetic model
module tb_neg_abs_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, iv, ordy;
    logic [31:0] id;
    logic [1:0] im;
    int sel;
    int ncmp = 0, nerr = 0;
    logic ir8, v8, ovf8, z8, ir1, v1, ovf1, z1, ir16, v16, ovf16, z16;
    logic [31:0] d8, d1;
    logic [15:0] d16;
    logic o_ir, o_v, o_ovf, o_z;
    logic [31:0] o_d;
    neg_abs_unit #(.WIDTH(32), .DIGIT(8)) u8 (.clk(clk), .reset(reset), .in_valid(iv && sel == 0), .in_ready(ir8),
        .in_data(id), .in_mode(im), .out_valid(v8), .out_ready(ordy), .out_data(d8), .out_ovf(ovf8), .out_zero(z8));
    neg_abs_unit #(.WIDTH(32), .DIGIT(1)) u1 (.clk(clk), .reset(reset), .in_valid(iv && sel == 1), .in_ready(ir1),
        .in_data(id), .in_mode(im), .out_valid(v1), .out_ready(ordy), .out_data(d1), .out_ovf(ovf1), .out_zero(z1));
    neg_abs_unit #(.WIDTH(16), .DIGIT(16)) u16 (.clk(clk), .reset(reset), .in_valid(iv && sel == 2), .in_ready(ir16),
        .in_data(id[15:0]), .in_mode(im), .out_valid(v16), .out_ready(ordy), .out_data(d16), .out_ovf(ovf16), .out_zero(z16));
    always_comb begin
        o_ir = sel == 0 ? ir8 : sel == 1 ? ir1 : ir16;
        o_v = sel == 0 ? v8 : sel == 1 ? v1 : v16;
        o_ovf = sel == 0 ? ovf8 : sel == 1 ? ovf1 : ovf16;
        o_z = sel == 0 ? z8 : sel == 1 ? z1 : z16;
        o_d = sel == 0 ? d8 : sel == 1 ? d1 : {16'h0, d16};
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Signed-integer view of the operation; out-of-range results report overflow and return the operand.
    task automatic model(input int w, input logic [1:0] m, input logic [31:0] a, output logic [31:0] r, output logic o);
        longint lim, sa, x;
        lim = longint'(1) << (w - 1);
        sa = longint'({32'h0, a}) & (2 * lim - 1);
        if (sa >= lim) sa -= 2 * lim;
        x = m == 0 ? sa : m == 1 ? -sa : m == 2 ? (sa < 0 ? -sa : sa) : (sa < 0 ? sa : -sa);
        o = x >= lim || x < -lim;
        if (o) x = sa;
        r = 32'(x & (2 * lim - 1));
    endtask
    task automatic run_op(input logic [1:0] m, input logic [31:0] a, input string tag);
        int n, lat;
        logic [31:0] er;
        logic eo;
        n = sel == 0 ? 4 : sel == 1 ? 32 : 1;
        model(sel == 2 ? 16 : 32, m, a, er, eo);
        chk({tag, " ready"}, o_ir, 1);
        id = a;
        im = m;
        iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        lat = 0;
        while (!o_v && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, n);
        chk({tag, " data"}, o_d, er);
        chk({tag, " ovf"}, o_ovf, eo);
        chk({tag, " zero"}, o_z, er == 0);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk({tag, " idle"}, {o_v, o_ir}, 2'b01);
    endtask
    initial begin
        logic [31:0] er, ra;
        logic eo, seen;
        int lat;
        reset = 1'b1;
        iv = 1'b0;
        ordy = 1'b0;
        id = '0;
        im = '0;
        sel = 0;
        repeat (2) @(negedge clk);
        chk("reset state", {o_v, o_ir, o_ovf, o_z}, 4'b0000);
        chk("reset data", o_d, 0);
        iv = 1'b1;
        id = 32'h5;
        im = 2'd1;
        @(negedge clk);
        iv = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("reset beats valid", {o_v, o_ir}, 2'b01);
        run_op(2'd1, 32'h00000005, "neg5");
        run_op(2'd2, 32'h80000000, "abs_min");
        run_op(2'd2, 32'hFFFFFFF9, "abs_m7");
        run_op(2'd3, 32'h00000007, "nabs7");
        run_op(2'd3, 32'h80000000, "nabs_min");
        run_op(2'd1, 32'h00000000, "neg0");
        run_op(2'd1, 32'h00000100, "neg100");
        run_op(2'd1, 32'h80000000, "neg_min");
        run_op(2'd0, 32'h80000000, "pass_min");
        model(32, 2'd1, 32'hCAFE0001, er, eo);
        id = 32'hCAFE0001;
        im = 2'd1;
        iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        lat = 0;
        while (!o_v && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp latency", lat, 4);
        for (int i = 0; i < 3; i++) begin
            iv = 1'b1;
            id = $urandom;
            im = 2'($urandom_range(3));
            @(negedge clk);
            chk("bp hold", {o_v, o_ir}, 2'b10);
            chk("bp data", o_d, er);
        end
        iv = 1'b0;
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk("bp release", {o_v, o_ir}, 2'b01);
        chk("bp data kept", o_d, er);
        run_op(2'd3, 32'h00001234, "after_bp");
        id = 32'h12345678;
        im = 2'd1;
        iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset ready", o_ir, 0);
        reset = 1'b0;
        chk("mid reset outs", {o_v, o_ovf, o_z}, 3'b000);
        chk("mid reset data", o_d, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= o_v;
        end
        chk("no partial result", seen, 0);
        run_op(2'd1, 32'h00000001, "post_rst");
        repeat (40) begin
            case ($urandom_range(5))
                0: ra = 32'h80000000;
                1: ra = 32'h0;
                2: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            run_op(2'($urandom_range(3)), ra, "rnd8");
        end
        sel = 1;
        run_op(2'd1, 32'h00000001, "d1_neg1");
        repeat (4) run_op(2'($urandom_range(3)), $urandom, "rnd1");
        sel = 2;
        run_op(2'd0, 32'h0000ABCD, "d16_pass");
        run_op(2'd2, 32'h00008000, "d16_abs_min");
        repeat (8) run_op(2'($urandom_range(3)), $urandom, "rnd16");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/neg_abs_unit.md
# neg_abs_unit

Parametrised, digit-serial two's-complement arithmetic unit. It is the successor to the fixed 32-bit combinational negator: a WIDTH-bit operand is processed DIGIT bits per clock. Four modes are supported: pass, negate, absolute value, negative absolute value. Results carry overflow and zero flags. It sits between operand registers and the ALU result mux, with valid/ready handshakes on both sides, so a narrow adder can serve wide operands.

## Interface
- WIDTH, 32, operand/result width in bits; ≥ 2.
- DIGIT, 8, bits processed per cycle; must divide WIDTH exactly; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- in_valid  input  1  operand and mode present.
- in_ready  output  1  unit can accept an operand.
- in_data  input  WIDTH  operand, two's complement.
- in_mode  input  2  0 = pass, 1 = negate, 2 = abs, 3 = nabs (−|a|).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  result not representable; out_data = in_data in that case.
- out_zero  output  1  out_data == 0.

## Operation
- N = WIDTH/DIGIT digit cycles per operation.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on in_valid && in_ready.
  - BUSY → DONE after N digit cycles.
  - DONE → IDLE on out_ready.
- in_ready = (state == IDLE) && !reset. in_valid in any other state is ignored.
- At accept, the unit latches in_data, a digit counter (cleared to 0) and a flag neg:
  - neg = (mode==1) | (mode==2 & a[WIDTH-1]) | (mode==3 & !a[WIDTH-1]).
  - carry is initialised to neg.
- Each BUSY cycle takes digit i = bits [i·DIGIT +: DIGIT], LSB digit first:
  - sum = (neg ? ~digit : digit) + carry, computed DIGIT+1 bits wide.
  - Low DIGIT bits are written to the result register at digit i.
  - carry ← sum[DIGIT]; the counter increments.
- The carry out of the final digit is discarded (modulo 2^WIDTH).
- out_ovf = neg && (a == 100…0). This is decided at accept and applies to negate and abs of the most-negative value. nabs never overflows.
- In the overflow case the arithmetic naturally yields 100…0, equal to a. No special path is needed, but the bench checks equality.
- out_zero is registered, computed from the completed result on entry to DONE.
- Pass mode (neg = 0, carry = 0) still takes N cycles. Latency is mode-independent.
- out_data, out_ovf and out_zero are held stable from entry to DONE until the handshake completes. They are not cleared on leaving DONE; they remain at their last value until the next DONE entry.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_ovf 0, out_zero 0, carry 0, counter 0.
- in_ready is 0 in any cycle with reset high.
- Accept at edge E0. Digits are processed at edges E1..EN; out_valid is 1 after EN.
  - Latency from accept to out_valid = N cycles.
- With out_ready held high, the result is consumed at edge EN+1 and in_ready returns after it.
- Peak throughput: one operation per N+2 cycles. There is no overlap of output handshake and new accept.
- out_valid is 1 exactly when state == DONE; no combinational path from out_ready to out_valid.
- Reset mid-BUSY or mid-DONE discards the operation:
  - Next cycle: IDLE, out_valid 0, all outputs at reset values.
  - No partial result is emitted.
- Simultaneous reset and in_valid: reset wins, nothing is accepted.
- Backpressure: out_ready low holds DONE indefinitely. All outputs are stable and in_ready stays 0.
- DIGIT == WIDTH: N = 1, single-cycle BUSY, latency 1.

## Test plan
- WIDTH=32, DIGIT=8, negate 0x00000005 → out_data 0xFFFFFFFB, ovf 0, zero 0, out_valid exactly 4 cycles after accept.
- abs 0x80000000 → out_data 0x80000000, ovf 1; abs 0xFFFFFFF9 → 0x00000007, ovf 0; nabs 0x00000007 → 0xFFFFFFF9; nabs 0x80000000 → 0x80000000, ovf 0.
- negate 0x00000000 → 0x00000000, zero 1, ovf 0; checks carry propagating through all 4 digits. Negate 0x00000100 → 0xFFFFFF00; checks carry stopping mid-operand.
- Backpressure: out_ready low for 3 cycles after out_valid. out_data/flags are held, in_ready is 0, and in_valid pulses with other data are ignored. out_ready high → IDLE next cycle, then the next operand is accepted.
- Reset asserted in the 2nd BUSY cycle of negate 0x12345678 → out_valid never rises, outputs are 0. A following negate 0x00000001 yields 0xFFFFFFFF with correct latency.
- WIDTH=32, DIGIT=1: negate 0x00000001 → 0xFFFFFFFF after 32 cycles. WIDTH=16, DIGIT=16: pass 0xABCD → 0xABCD after 1 cycle. Random operands in all modes are checked against a reference model.
